// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with 2-bit saturating counters.
// Combinational fetch lookup, resolved-branch update, and a registered
// one-cycle flush carrying the correct next PC on a mispredict.
module branch_predict_unit #(
  parameter int WORD    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] BPU_fetch_pc,
  output logic            BPU_pred_taken,
  output logic [WORD-1:0] BPU_pred_pc,
  input  logic            BPU_upd_valid,
  input  logic [WORD-1:0] BPU_upd_pc,
  input  logic            BPU_upd_taken,
  input  logic [WORD-1:0] BPU_upd_target,
  input  logic            BPU_upd_pred_taken,
  input  logic [WORD-1:0] BPU_upd_pred_pc,
  output logic            BPU_flush,
  output logic [WORD-1:0] BPU_flush_pc,
  output logic [31:0]     BPU_mispredict_cnt
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = WORD - 2 - IDX;

  // BTB storage; only valid and ctr carry reset state
  logic            r_valid  [ENTRIES];
  logic [TAGW-1:0] r_tag    [ENTRIES];
  logic [WORD-1:0] r_target [ENTRIES];
  logic [1:0]      r_ctr    [ENTRIES];

  logic            r_flush;
  logic [WORD-1:0] r_flush_pc;
  logic [31:0]     r_mispredict_cnt;

  // Lookup path
  logic [IDX-1:0]  w_f_idx;
  logic [TAGW-1:0] w_f_tag;
  logic            w_f_hit;
  logic            w_pred_taken;

  // Update path
  logic [IDX-1:0]  w_u_idx;
  logic [TAGW-1:0] w_u_tag;
  logic            w_u_hit;
  logic [1:0]      w_u_ctr_nxt;
  logic [WORD-1:0] w_cpc;
  logic            w_mispredict;

  // Instruction-alignment bits carry no information for indexing
  logic            w_unused_lsbs;
  assign w_unused_lsbs = ^{BPU_fetch_pc[1:0], BPU_upd_pc[1:0]};

  assign w_f_idx = BPU_fetch_pc[IDX+1:2];
  assign w_f_tag = BPU_fetch_pc[WORD-1:IDX+2];
  assign w_u_idx = BPU_upd_pc[IDX+1:2];
  assign w_u_tag = BPU_upd_pc[WORD-1:IDX+2];

  // Fetch lookup: forced to not-taken while reset is asserted
  always_comb begin
    w_f_hit      = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    w_pred_taken = !rst && w_f_hit && r_ctr[w_f_idx][1];
    BPU_pred_taken = w_pred_taken;
    BPU_pred_pc    = w_pred_taken ? r_target[w_f_idx] : (BPU_fetch_pc + WORD'(4));
  end

  // Update-side hit detection, saturating counter step, mispredict decision
  always_comb begin
    w_u_hit     = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    w_u_ctr_nxt = r_ctr[w_u_idx];
    if (BPU_upd_taken) begin
      if (r_ctr[w_u_idx] != 2'b11) w_u_ctr_nxt = r_ctr[w_u_idx] + 2'b01;
    end else begin
      if (r_ctr[w_u_idx] != 2'b00) w_u_ctr_nxt = r_ctr[w_u_idx] - 2'b01;
    end
    w_cpc        = BPU_upd_taken ? BPU_upd_target : (BPU_upd_pc + WORD'(4));
    w_mispredict = BPU_upd_valid &&
                   ((BPU_upd_taken != BPU_upd_pred_taken) || (w_cpc != BPU_upd_pred_pc));
  end

  // Valid bits and counters: train on hit, allocate on taken miss
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (BPU_upd_valid) begin
      if (w_u_hit) begin
        r_ctr[w_u_idx] <= w_u_ctr_nxt;
      end else if (BPU_upd_taken) begin
        r_valid[w_u_idx] <= 1'b1;
        r_ctr[w_u_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target payload; rewriting the tag on a hit is harmless
  always_ff @(posedge clk) begin
    if (!rst && BPU_upd_valid && BPU_upd_taken) begin
      r_tag[w_u_idx]    <= w_u_tag;
      r_target[w_u_idx] <= BPU_upd_target;
    end
  end

  // Registered flush pulse, correct PC and wrapping mispredict counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush          <= 1'b0;
      r_flush_pc       <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      r_flush <= w_mispredict;
      if (w_mispredict) begin
        r_flush_pc       <= w_cpc;
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
      end
    end
  end

  assign BPU_flush          = r_flush;
  assign BPU_flush_pc       = r_flush_pc;
  assign BPU_mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with an expectation queue.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] mis_cnt;

  branch_predict_unit #(.WORD(32), .ENTRIES(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .BPU_fetch_pc       (fetch_pc),
    .BPU_pred_taken     (pred_taken),
    .BPU_pred_pc        (pred_pc),
    .BPU_upd_valid      (upd_valid),
    .BPU_upd_pc         (upd_pc),
    .BPU_upd_taken      (upd_taken),
    .BPU_upd_target     (upd_target),
    .BPU_upd_pred_taken (upd_pred_taken),
    .BPU_upd_pred_pc    (upd_pred_pc),
    .BPU_flush          (flush),
    .BPU_flush_pc       (flush_pc),
    .BPU_mispredict_cnt (mis_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  localparam int S_PT = 0, S_PPC = 1, S_FL = 2, S_FPC = 3, S_CNT = 4;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_fpc = '0;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_PT:    return {31'b0, pred_taken};
      S_PPC:   return pred_pc;
      S_FL:    return {31'b0, flush};
      S_FPC:   return flush_pc;
      default: return mis_cnt;
    endcase
  endfunction

  task automatic push(string tag, int sel, logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = observe(e.sel);
      n_vec++;
      assert (o === e.exp) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic push_look(string tag, logic t, logic [31:0] pc);
    push({tag, "_pt"}, S_PT, {31'b0, t});
    push({tag, "_ppc"}, S_PPC, pc);
  endtask

  task automatic push_state(string tag, logic f);
    push({tag, "_flush"}, S_FL, {31'b0, f});
    push({tag, "_fpc"}, S_FPC, m_fpc);
    push({tag, "_cnt"}, S_CNT, m_cnt);
  endtask

  // Combinational lookup check, realigned to the falling edge afterwards
  task automatic lookup(string tag, logic [31:0] pc, logic t, logic [31:0] ppc);
    fetch_pc = pc;
    push_look(tag, t, ppc);
    #1;
    drain();
    @(negedge clk);
  endtask

  // One update cycle; expectations already queued are checked pre-edge
  task automatic update(string tag, logic [31:0] pc, logic tk, logic [31:0] tgt,
                        logic ptk, logic [31:0] ppc);
    logic [31:0] cpc;
    logic        mis;
    cpc = tk ? tgt : pc + 32'd4;
    mis = (tk != ptk) || (cpc != ppc);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_pc = ppc;
    #1;
    drain();
    if (mis) begin
      m_cnt = m_cnt + 32'd1;
      m_fpc = cpc;
    end
    push_state(tag, mis);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    drain();
    @(negedge clk);
  endtask

  task automatic idle(string tag);
    @(posedge clk);
    #1;
    push_state(tag, 1'b0);
    drain();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; fetch_pc = 32'h1C000000; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_pc = '0;
    #1;
    push_look("rst_look", 1'b0, 32'h1C000004);
    drain();
    @(negedge clk);
    rst = 1'b0;
    #1;
    push_state("post_rst", 1'b0);
    drain();
    lookup("look0", 32'h1C000000, 1'b0, 32'h1C000004);

    // Allocate on taken miss, then predicted taken
    update("alloc", 32'h1C000010, 1'b1, 32'h1C000100, 1'b0, 32'h1C000014);
    idle("alloc_idle");
    lookup("look_alloc", 32'h1C000010, 1'b1, 32'h1C000100);

    // Back-to-back not-taken: ctr 10->01->00
    update("nt1", 32'h1C000010, 1'b0, 32'h1C000100, 1'b1, 32'h1C000100);
    lookup("look_nt1", 32'h1C000010, 1'b0, 32'h1C000014);
    update("nt2a", 32'h1C000010, 1'b0, 32'h1C000100, 1'b1, 32'h1C000100);
    update("nt2b", 32'h1C000010, 1'b0, 32'h1C000100, 1'b1, 32'h1C000100);
    idle("nt2_idle");
    lookup("look_nt2", 32'h1C000010, 1'b0, 32'h1C000014);
    update("nt3", 32'h1C000010, 1'b0, 32'h1C000100, 1'b0, 32'h1C000014);
    // From 00 one taken gives 01 (still not taken), a second gives 10
    update("tk1", 32'h1C000010, 1'b1, 32'h1C000100, 1'b0, 32'h1C000014);
    lookup("look_tk1", 32'h1C000010, 1'b0, 32'h1C000014);
    update("tk2", 32'h1C000010, 1'b1, 32'h1C000100, 1'b0, 32'h1C000014);
    lookup("look_tk2", 32'h1C000010, 1'b1, 32'h1C000100);

    // Aliasing replacement; same-cycle lookup sees pre-update contents
    fetch_pc = 32'h1C000010;
    push_look("same_cyc", 1'b1, 32'h1C000100);
    update("alias", 32'h1C000050, 1'b1, 32'h1C000200, 1'b0, 32'h1C000054);
    lookup("look_alias_old", 32'h1C000010, 1'b0, 32'h1C000014);
    lookup("look_alias_new", 32'h1C000050, 1'b1, 32'h1C000200);

    // Correct prediction vs right direction with wrong target
    update("realloc", 32'h1C000010, 1'b1, 32'h1C000100, 1'b0, 32'h1C000014);
    update("correct", 32'h1C000010, 1'b1, 32'h1C000100, 1'b1, 32'h1C000100);
    update("bad_tgt", 32'h1C000010, 1'b1, 32'h1C000100, 1'b1, 32'h1C000104);
    idle("bad_tgt_idle");

    // Reset asserted mid-update with an allocating, mispredicting update
    upd_valid = 1'b1; upd_pc = 32'h1C000080; upd_taken = 1'b1;
    upd_target = 32'h1C000300; upd_pred_taken = 1'b0; upd_pred_pc = 32'h1C000084;
    fetch_pc = 32'h1C000050;
    #2;
    rst = 1'b1;
    m_cnt = '0; m_fpc = '0;
    #1;
    push_look("rst_mid_look", 1'b0, 32'h1C000054);
    drain();
    @(posedge clk);
    #1;
    push_state("rst_mid", 1'b0);
    drain();
    @(negedge clk);
    upd_valid = 1'b0;
    rst = 1'b0;
    idle("rst_mid_idle");
    lookup("look_rst_80", 32'h1C000080, 1'b0, 32'h1C000084);
    lookup("look_rst_50", 32'h1C000050, 1'b0, 32'h1C000054);

    // Counter wrap
    force dut.r_mispredict_cnt = 32'hFFFFFFFF;
    #1;
    release dut.r_mispredict_cnt;
    m_cnt = 32'hFFFFFFFF;
    push("cnt_preload", S_CNT, m_cnt);
    #1;
    drain();
    @(negedge clk);
    update("wrap", 32'h1C000020, 1'b1, 32'h1C000400, 1'b0, 32'h1C000024);
    idle("wrap_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
